wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of completion requesters (0=scalar ALU, 1=scalar LD/ST, 2=matrix LD/ST, 3=GEMM).
REQ-002 SHALL have parameter MAT_MASK, default 4'b1100, bit i set marks requester i as matrix-destination.
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port nRST  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  requester i holds a completion.
REQ-006 SHALL have port req_ready  output  NREQ  arbiter accepts requester i this cycle.
REQ-007 SHALL have port req_rd  input  NREQ x 5  destination register; matrix requesters use bits [3:0], bit 4 ignored.
REQ-008 SHALL have port req_data  input  NREQ x 32  scalar result; ignored for matrix requesters.
REQ-009 SHALL have port freeze  input  1  suppress grants this cycle.
REQ-010 SHALL have port wb_valid  output  1  registered writeback valid.
REQ-011 SHALL have port wb_is_mat  output  1  registered; writeback targets the matrix register file.
REQ-012 SHALL have port wb_rd  output  5  registered destination (matrix: zero-extended 4 bits).
REQ-013 SHALL have port wb_data  output  32  registered data (0 when wb_is_mat).
REQ-014 SHALL have port wb_src  output  2  registered index of the granted requester.
REQ-015 SHALL have ports s_clr_en/s_clr_sel (1/5) and m_clr_en/m_clr_sel (1/4)  outputs  register-status-table clear, combinational from wb_* registers.

Function
REQ-016 SHALL hold one entry per requester (held[i], rd, data); req_ready[i] = ~held[i] | grant[i].
REQ-017 SHALL capture an entry on req_valid[i] & req_ready[i]; a capture and a grant on the same i in one cycle SHALL leave the new entry held.
REQ-018 SHALL grant at most one held entry per cycle, round-robin: search starts at rr_ptr, wraps NREQ-1 to 0.
REQ-019 SHALL update rr_ptr to (winner+1) mod NREQ on a grant; SHALL leave rr_ptr unchanged with no grant.
REQ-020 SHALL, on freeze=1, issue no grant, clear wb_valid at the next edge, keep held entries and rr_ptr, and drive req_ready = ~held.
REQ-021 SHALL load wb_* from the winner at the edge ending the grant cycle; wb_valid=0 next cycle when no grant.
REQ-022 SHALL yield latency: req accepted edge N -> eligible cycle N+1 -> wb_valid visible after edge N+1 (minimum 2 edges, back-to-back 1 writeback/cycle).
REQ-023 SHALL drive s_clr_en = wb_valid & ~wb_is_mat, s_clr_sel = wb_rd; m_clr_en = wb_valid & wb_is_mat, m_clr_sel = wb_rd[3:0].
REQ-024 SHALL guarantee any held entry is granted within NREQ non-frozen cycles (no starvation).
REQ-025 SHALL NOT check or reorder same-rd conflicts; ordering is a dispatch (WAW) responsibility.

Reset
REQ-026 SHALL, on nRST=0, asynchronously clear all held flags, rr_ptr=0, wb_valid=0, wb_is_mat=0, wb_rd=0, wb_data=0, wb_src=0.
REQ-027 SHALL discard held entries on reset mid-operation; req_ready = all ones in the first cycle after reset release.

Structure
REQ-028 SHALL place WB_NREQ, wb_src_t enum (WB_ALU, WB_S_LDST, WB_M_LDST, WB_GEMM) and wb_req_t struct in datapath_pkg.
REQ-029 SHALL instantiate one sub-module rr_arbiter (NREQ-way, request vector + pointer -> one-hot grant + index), purely combinational.

Verification
REQ-030 SHALL test single request: ALU rd=5 data=0xDEAD_BEEF at edge 0 -> wb_valid, wb_rd=5, wb_data=0xDEADBEEF, s_clr_en, s_clr_sel=5 after edge 1.
REQ-031 SHALL test all four valid simultaneously from reset -> wb_src sequence 0,1,2,3 on four consecutive cycles; m_clr_en on 3rd/4th.
REQ-032 SHALL test fairness: ALU valid every cycle, GEMM rd=9 once -> GEMM granted within 4 cycles, m_clr_sel=9.
REQ-033 SHALL test freeze 3 cycles with 2 entries held -> wb_valid=0, req_ready=0 for held requesters, both drain after release, none lost.
REQ-034 SHALL test pass-through: ALU held and granted while new ALU request valid -> req_ready[0]=1, new entry written back next cycle.
REQ-035 SHALL test reset asserted with 3 entries held -> all outputs 0 immediately, no writeback after release.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types for the writeback path.
// WB_NREQ   : number of completion requesters feeding the writeback arbiter.
// wb_src_t  : requester identities (scalar ALU, scalar LD/ST, matrix LD/ST, GEMM).
// wb_req_t  : one held completion (destination register + scalar result).
// wb_shape  : reshapes an entry for the register file it targets.
package datapath_pkg;

  localparam int WB_NREQ = 4;
  localparam int WB_RD_W = 5;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {
    WB_ALU    = 2'd0,
    WB_S_LDST = 2'd1,
    WB_M_LDST = 2'd2,
    WB_GEMM   = 2'd3
  } wb_src_t;

  typedef struct packed {
    logic [WB_RD_W-1:0]   rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // Matrix destinations only have 16 registers and carry no scalar data.
  function automatic wb_req_t wb_shape(input logic is_mat, input wb_req_t e);
    wb_req_t r;
    r = e;
    if (is_mat) begin
      r.rd   = {1'b0, e.rd[3:0]};
      r.data = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// req   : request vector
// ptr   : index at which the search starts (wraps NREQ-1 -> 0)
// grant : one-hot grant (all zero when no request)
// idx   : index of the granted request
// any   : at least one request granted
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW:0]   k_wide;
  logic [IW-1:0] k;

  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    k_wide = '0;
    k      = '0;
    for (int off = 0; off < NREQ; off++) begin
      k_wide = {1'b0, ptr} + (IW+1)'(off);
      if (k_wide >= (IW+1)'(NREQ)) k_wide = k_wide - (IW+1)'(NREQ);
      k = k_wide[IW-1:0];
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: holds one completion per requester and retires at most
// one per cycle to the scalar or matrix register file, round-robin.
// CLK, nRST             : clock, asynchronous active-low reset
// req_valid/req_ready   : per-requester completion handshake
// req_rd/req_data       : per-requester destination and scalar result
// freeze                : suppress grants this cycle
// wb_valid/wb_is_mat/wb_rd/wb_data/wb_src : registered writeback
// s_clr_en/s_clr_sel, m_clr_en/m_clr_sel  : register-status-table clears
module wb_arbiter
  import datapath_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  parameter logic [NREQ-1:0] MAT_MASK = 4'b1100
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][4:0]  req_rd,
  input  logic [NREQ-1:0][31:0] req_data,
  input  logic                  freeze,
  output logic                  wb_valid,
  output logic                  wb_is_mat,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic [1:0]            wb_src,
  output logic                  s_clr_en,
  output logic [4:0]            s_clr_sel,
  output logic                  m_clr_en,
  output logic [3:0]            m_clr_sel
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] held;
  wb_req_t         ent [NREQ];
  logic [IW-1:0]   rr_ptr;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic            win_mat;
  wb_req_t         win_ent;
  logic [NREQ-1:0] accept;

  // An entry becomes eligible the cycle after capture; freeze masks all.
  assign eligible = held & {NREQ{~freeze}};

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // A slot being drained this cycle can take a new completion at once.
  assign req_ready = ~held | grant;
  assign accept    = req_valid & req_ready;

  assign win_mat = MAT_MASK[win_idx];
  assign win_ent = wb_shape(win_mat, ent[win_idx]);

  // ---- entry stage: held flags and round-robin pointer ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      held   <= '0;
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        // Capture wins over grant so a pass-through entry stays held.
        if (accept[i])     held[i] <= 1'b1;
        else if (grant[i]) held[i] <= 1'b0;
      end
      if (win_any) begin
        if (win_idx == IW'(NREQ-1)) rr_ptr <= '0;
        else                        rr_ptr <= win_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i]) ent[i] <= '{rd: req_rd[i], data: req_data[i]};
    end
  end

  // ---- writeback stage ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_valid  <= 1'b0;
      wb_is_mat <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_src    <= '0;
    end else begin
      wb_valid <= win_any;
      if (win_any) begin
        wb_is_mat <= win_mat;
        wb_rd     <= win_ent.rd;
        wb_data   <= win_ent.data;
        wb_src    <= 2'(win_idx);
      end
    end
  end

  assign s_clr_en  = wb_valid & ~wb_is_mat;
  assign s_clr_sel = wb_rd;
  assign m_clr_en  = wb_valid & wb_is_mat;
  assign m_clr_sel = wb_rd[3:0];

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: scenario tasks with a per-requester scoreboard.
module tb_wb_arbiter;
  import datapath_pkg::*;

  localparam int NREQ = 4;
  localparam logic [3:0] MASK = 4'b1100;

  logic                  CLK;
  logic                  nRST;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][4:0]  req_rd;
  logic [NREQ-1:0][31:0] req_data;
  logic                  freeze;
  logic                  wb_valid;
  logic                  wb_is_mat;
  logic [4:0]            wb_rd;
  logic [31:0]           wb_data;
  logic [1:0]            wb_src;
  logic                  s_clr_en;
  logic [4:0]            s_clr_sel;
  logic                  m_clr_en;
  logic [3:0]            m_clr_sel;

  wb_arbiter #(.NREQ(NREQ), .MAT_MASK(MASK)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .freeze(freeze),
    .wb_valid(wb_valid), .wb_is_mat(wb_is_mat), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_src(wb_src),
    .s_clr_en(s_clr_en), .s_clr_sel(s_clr_sel),
    .m_clr_en(m_clr_en), .m_clr_sel(m_clr_sel)
  );

  typedef struct packed {
    logic [1:0]  src;
    logic        is_mat;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb [NREQ][$];
  int n_run;
  int n_fail;
  logic [NREQ-1:0] hs_last;
  logic [51:0] obs_now;

  assign obs_now = {wb_valid, wb_is_mat, wb_rd, wb_data, wb_src,
                    s_clr_en, s_clr_sel, m_clr_en, m_clr_sel};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  function automatic exp_t mk_exp(input int i, input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    logic [3:0] m;
    m = MASK;
    e.src    = 2'(i);
    e.is_mat = m[i];
    e.rd     = m[i] ? {1'b0, rd[3:0]} : rd;
    e.data   = m[i] ? 32'h0 : d;
    return e;
  endfunction

  function automatic logic [51:0] exp_vec(input exp_t e);
    return {1'b1, e.is_mat, e.rd, e.data, e.src, ~e.is_mat, e.rd, e.is_mat, e.rd[3:0]};
  endfunction

  task automatic pop_exp(input int s, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    if (s >= 0 && s < NREQ && sb[s].size() > 0) begin
      e  = sb[s].pop_front();
      ok = 1'b1;
    end
  endtask

  // Record accepted completions just before the edge, then step one cycle.
  task automatic tick();
    #1;
    hs_last = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++)
      if (hs_last[i]) sb[i].push_back(mk_exp(i, req_rd[i], req_data[i]));
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    req_valid = '0;
    freeze = 1'b0;
    for (int i = 0; i < NREQ; i++) sb[i].delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #1;
    n_run++;
    if (obs_now !== 52'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", obs_now);
    end
    n_run++;
    if (req_ready !== 4'hF) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1111", req_ready);
    end
    do_reset();
    #1;
    n_run++;
    if (req_ready !== 4'hF || wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: ready=%b wb_valid=%b want 1111/0", req_ready, wb_valid);
    end
  endtask

  task automatic test_single();
    exp_t e; bit ok;
    do_reset();
    req_valid = 4'b0001; req_rd[0] = 5'd5; req_data[0] = 32'hDEAD_BEEF;
    tick();
    req_valid = '0;
    n_run++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_latency: wb_valid=%b after edge 0 want 0", wb_valid);
    end
    tick();
    n_run++;
    pop_exp(0, e, ok);
    if (!ok || obs_now !== exp_vec(e)) begin
      n_fail++; $display("FAIL single_wb: got %h want %h (ok=%0d)", obs_now, exp_vec(e), ok);
    end
    tick();
    n_run++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: wb_valid=%b want 0", wb_valid);
    end
  endtask

  task automatic test_all4();
    exp_t e; bit ok;
    do_reset();
    req_valid = 4'hF;
    req_rd[0] = 5'd1;    req_data[0] = 32'h1111_1111;
    req_rd[1] = 5'd2;    req_data[1] = 32'h2222_2222;
    req_rd[2] = 5'h13;   req_data[2] = 32'h3333_3333;
    req_rd[3] = 5'h1C;   req_data[3] = 32'h4444_4444;
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_run++;
      pop_exp(k, e, ok);
      if (!ok || obs_now !== exp_vec(e)) begin
        n_fail++; $display("FAIL all4_slot%0d: got %h want %h (ok=%0d)", k, obs_now, exp_vec(e), ok);
      end
    end
    tick();
    n_run++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL all4_idle: wb_valid=%b want 0", wb_valid);
    end
  endtask

  task automatic test_fairness();
    exp_t e; bit ok;
    int alu_k;
    int gemm_at;
    int left;
    do_reset();
    alu_k = 0;
    gemm_at = -1;
    req_valid = 4'b1001;
    req_rd[0] = 5'd7; req_data[0] = 32'hA000_0000;
    req_rd[3] = 5'd9; req_data[3] = 32'hFFFF_FFFF;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (hs_last[3]) req_valid[3] = 1'b0;
      if (hs_last[0]) begin
        alu_k++;
        req_data[0] = 32'hA000_0000 + 32'(alu_k);
      end
      if (c >= 6) req_valid[0] = 1'b0;
      if (wb_valid === 1'b1) begin
        n_run++;
        pop_exp(int'(wb_src), e, ok);
        if (!ok || obs_now !== exp_vec(e)) begin
          n_fail++; $display("FAIL fair_wb_c%0d: got %h want %h (ok=%0d)", c, obs_now, exp_vec(e), ok);
        end
        if (wb_src == 2'd3 && gemm_at < 0) gemm_at = c;
      end
    end
    n_run++;
    if (gemm_at < 1 || gemm_at > 4) begin
      n_fail++; $display("FAIL fair_gemm_latency: granted at cycle %0d want 1..4", gemm_at);
    end
    left = 0;
    for (int i = 0; i < NREQ; i++) left += sb[i].size();
    n_run++;
    if (left != 0) begin
      n_fail++; $display("FAIL fair_drain: %0d entries never written back want 0", left);
    end
  endtask

  task automatic test_freeze();
    exp_t e; bit ok;
    int left;
    do_reset();
    req_valid = 4'b0111;
    req_rd[0] = 5'd3; req_data[0] = 32'h0000_0A0A;
    req_rd[1] = 5'd4; req_data[1] = 32'h0000_0B0B;
    req_rd[2] = 5'd6; req_data[2] = 32'h0000_0C0C;
    tick();
    req_valid = '0;
    tick();
    n_run++;
    pop_exp(0, e, ok);
    if (!ok || obs_now !== exp_vec(e)) begin
      n_fail++; $display("FAIL frz_pre: got %h want %h (ok=%0d)", obs_now, exp_vec(e), ok);
    end
    freeze = 1'b1;
    #1;
    n_run++;
    if (req_ready !== 4'b1001) begin
      n_fail++; $display("FAIL frz_ready: got %b want 1001", req_ready);
    end
    for (int f = 0; f < 3; f++) begin
      tick();
      n_run++;
      if (wb_valid !== 1'b0 || req_ready !== 4'b1001) begin
        n_fail++; $display("FAIL frz_hold%0d: wb_valid=%b ready=%b want 0/1001", f, wb_valid, req_ready);
      end
    end
    freeze = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_run++;
      pop_exp(k, e, ok);
      if (!ok || obs_now !== exp_vec(e)) begin
        n_fail++; $display("FAIL frz_drain%0d: got %h want %h (ok=%0d)", k, obs_now, exp_vec(e), ok);
      end
    end
    tick();
    left = 0;
    for (int i = 0; i < NREQ; i++) left += sb[i].size();
    n_run++;
    if (wb_valid !== 1'b0 || left != 0) begin
      n_fail++; $display("FAIL frz_end: wb_valid=%b pending=%0d want 0/0", wb_valid, left);
    end
  endtask

  task automatic test_pass_through();
    exp_t e; bit ok;
    do_reset();
    req_valid = 4'b0001; req_rd[0] = 5'd10; req_data[0] = 32'h1234_5678;
    tick();
    req_rd[0] = 5'd11; req_data[0] = 32'h8765_4321;
    #1;
    n_run++;
    if (req_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL pass_ready: got %b want 1", req_ready[0]);
    end
    tick();
    req_valid = '0;
    n_run++;
    pop_exp(0, e, ok);
    if (!ok || obs_now !== exp_vec(e)) begin
      n_fail++; $display("FAIL pass_first: got %h want %h (ok=%0d)", obs_now, exp_vec(e), ok);
    end
    tick();
    n_run++;
    pop_exp(0, e, ok);
    if (!ok || obs_now !== exp_vec(e)) begin
      n_fail++; $display("FAIL pass_second: got %h want %h (ok=%0d)", obs_now, exp_vec(e), ok);
    end
    tick();
    n_run++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL pass_idle: wb_valid=%b want 0", wb_valid);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; bit ok;
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) begin
      req_rd[i] = 5'(i + 20);
      req_data[i] = 32'hC0DE_0000 + 32'(i);
    end
    tick();
    req_valid = '0;
    tick();
    n_run++;
    pop_exp(0, e, ok);
    if (!ok || obs_now !== exp_vec(e)) begin
      n_fail++; $display("FAIL rmid_pre: got %h want %h (ok=%0d)", obs_now, exp_vec(e), ok);
    end
    #2;
    nRST = 1'b0;
    #1;
    n_run++;
    if (obs_now !== 52'h0) begin
      n_fail++; $display("FAIL rmid_async_outputs: got %h want 0", obs_now);
    end
    n_run++;
    if (req_ready !== 4'hF) begin
      n_fail++; $display("FAIL rmid_ready_in_reset: got %b want 1111", req_ready);
    end
    for (int i = 0; i < NREQ; i++) sb[i].delete();
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    n_run++;
    if (req_ready !== 4'hF) begin
      n_fail++; $display("FAIL rmid_ready_after: got %b want 1111", req_ready);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_run++;
      if (wb_valid !== 1'b0) begin
        n_fail++; $display("FAIL rmid_no_wb%0d: wb_valid=%b want 0", c, wb_valid);
      end
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    hs_last = '0;
    nRST = 1'b1;
    req_valid = '0;
    req_rd = '0;
    req_data = '0;
    freeze = 1'b0;
    #3;
    test_reset();
    test_single();
    test_all4();
    test_fairness();
    test_freeze();
    test_pass_through();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
